// File: rtl/adj_pkg.sv
// Shared types for the parameter-adjust controller: FSM states, timer width, step direction.
package adj_pkg;

  localparam int unsigned TIMER_W = 24;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT,
    ST_WAIT_REL
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

endpackage

// File: rtl/adj_step_alu.sv
// Shared step datapath: applies one up/down step to a value, bounded by max.
// ADJ_SATURATE_EN selects saturation instead of wrap-around at the bounds.
module adj_step_alu
  import adj_pkg::*;
#(
  parameter int unsigned VAL_W  = 11,
  parameter int unsigned STEP_W = 10
) (
  input  logic [VAL_W-1:0]  value,
  input  logic [STEP_W-1:0] step,
  input  logic [VAL_W-1:0]  max_val,
  input  dir_t              dir,
  output logic [VAL_W-1:0]  result_c
);

  localparam int unsigned EXT_W = ((VAL_W > STEP_W) ? VAL_W : STEP_W) + 1;

  logic [EXT_W-1:0] value_x;
  logic [EXT_W-1:0] step_x;
  logic [EXT_W-1:0] max_x;
  logic [EXT_W-1:0] sum_x;
  logic [VAL_W-1:0] up_over;
  logic [VAL_W-1:0] down_under;

  assign value_x = EXT_W'(value);
  assign step_x  = EXT_W'(step);
  assign max_x   = EXT_W'(max_val);
  assign sum_x   = value_x + step_x;

`ifdef ADJ_SATURATE_EN
  assign up_over    = max_val;
  assign down_under = '0;
`else
  assign up_over    = '0;
  assign down_under = max_val;
`endif

  always_comb begin
    result_c = value;
    if (dir == DIR_UP) begin
      result_c = (sum_x > max_x) ? up_over : VAL_W'(sum_x);
    end else begin
      result_c = (value_x < step_x) ? down_under : VAL_W'(value_x - step_x);
    end
  end

endmodule

// File: rtl/param_adjust_ctrl.sv
// Button-driven parameter tuner: selection, hold-to-repeat stepping and value registers.
// Optional macro ADJ_SATURATE_EN (in adj_step_alu) saturates instead of wrapping.
module param_adjust_ctrl
  import adj_pkg::*;
#(
  parameter int unsigned         NUM_PARAMS    = 4,
  parameter int unsigned         VAL_W         = 11,
  parameter int unsigned         STEP_W        = 10,
  parameter logic [TIMER_W-1:0]  HOLD_DELAY    = 24'd6_500_000,
  parameter logic [TIMER_W-1:0]  REPEAT_PERIOD = 24'd1_625_000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           btn_up,
  input  logic                           btn_down,
  input  logic                           btn_next,
  input  logic [NUM_PARAMS*VAL_W-1:0]    init_vals,
  input  logic [NUM_PARAMS*VAL_W-1:0]    max_vals,
  input  logic [NUM_PARAMS*STEP_W-1:0]   steps,
  input  logic                           load_init,
  output logic [NUM_PARAMS*VAL_W-1:0]    values,
  output logic [$clog2(NUM_PARAMS)-1:0]  sel,
  output logic                           step_pulse
);

  localparam int unsigned SEL_W = $clog2(NUM_PARAMS);
  localparam logic [TIMER_W-1:0] HOLD_LAST   = HOLD_DELAY - TIMER_W'(1);
  localparam logic [TIMER_W-1:0] REPEAT_LAST = REPEAT_PERIOD - TIMER_W'(1);

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  dir_t                 dir_q, dir_d;
  logic                 next_q;
  logic                 pulse_d;
  logic [VAL_W-1:0]     val_q [NUM_PARAMS];
  logic [VAL_W-1:0]     val_d [NUM_PARAMS];
  logic [VAL_W-1:0]     init_a [NUM_PARAMS];
  logic [VAL_W-1:0]     max_a [NUM_PARAMS];
  logic [STEP_W-1:0]    step_a [NUM_PARAMS];
  logic [VAL_W-1:0]     alu_result_c;
  logic                 step_en_c;
  logic                 next_rise_c;
  dir_t                 cur_dir_c;

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_unpack
    assign init_a[g] = init_vals[g*VAL_W +: VAL_W];
    assign max_a[g]  = max_vals[g*VAL_W +: VAL_W];
    assign step_a[g] = steps[g*STEP_W +: STEP_W];
    assign values[g*VAL_W +: VAL_W] = val_q[g];
  end

  assign sel         = sel_q;
  assign next_rise_c = btn_next & ~next_q;
  assign cur_dir_c   = btn_up ? DIR_UP : DIR_DOWN;

  adj_step_alu #(
    .VAL_W  (VAL_W),
    .STEP_W (STEP_W)
  ) u_alu (
    .value    (val_q[sel_q]),
    .step     (step_a[sel_q]),
    .max_val  (max_a[sel_q]),
    .dir      (cur_dir_c),
    .result_c (alu_result_c)
  );

  // Next-state, timer, selection and value update
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    sel_d     = sel_q;
    dir_d     = dir_q;
    val_d     = val_q;
    pulse_d   = 1'b0;
    step_en_c = 1'b0;

    case (state_q)
      ST_INIT: begin
        val_d   = init_a;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (next_rise_c) begin
          sel_d = (sel_q == SEL_W'(NUM_PARAMS - 1)) ? '0 : sel_q + SEL_W'(1);
        end
        if (btn_up && btn_down) begin
          state_d = ST_WAIT_REL;
        end else if (btn_up || btn_down) begin
          step_en_c = 1'b1;
          timer_d   = '0;
          dir_d     = cur_dir_c;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        // Release and conflict checks win over a timer expiry
        if (!btn_up && !btn_down) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if ((btn_up && btn_down) || (cur_dir_c != dir_q)) begin
          state_d = ST_WAIT_REL;
        end else if (timer_q == ((state_q == ST_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
          step_en_c = 1'b1;
          timer_d   = '0;
          state_d   = ST_REPEAT;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_WAIT_REL: begin
        if (!btn_up && !btn_down) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (step_en_c) begin
      val_d[sel_q] = alu_result_c;
      pulse_d      = 1'b1;
    end

    // Reload overrides any step taken in the same cycle
    if (load_init) begin
      val_d   = init_a;
      pulse_d = 1'b0;
      timer_d = '0;
      state_d = (btn_up || btn_down || btn_next) ? ST_WAIT_REL : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      timer_q    <= '0;
      sel_q      <= '0;
      dir_q      <= DIR_UP;
      next_q     <= 1'b0;
      step_pulse <= 1'b0;
      for (int i = 0; i < NUM_PARAMS; i++) begin
        val_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      sel_q      <= sel_d;
      dir_q      <= dir_d;
      next_q     <= btn_next;
      step_pulse <= pulse_d;
      val_q      <= val_d;
    end
  end

endmodule

// File: tb/tb_param_adjust_ctrl.sv
// Directed self-checking bench for param_adjust_ctrl (wrap or ADJ_SATURATE_EN build).
module tb_param_adjust_ctrl;

  localparam int unsigned NP = 4;
  localparam int unsigned VW = 11;
  localparam int unsigned SW = 10;

  localparam logic [NP*VW-1:0] INIT_V = {11'd5, 11'd0, 11'd200, 11'd100};
  localparam logic [NP*VW-1:0] MAX_V  = {11'd5, 11'd10, 11'd479, 11'd639};
  localparam logic [NP*SW-1:0] STEP_V = {10'd1, 10'd3, 10'd1, 10'd10};

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              btn_up = 1'b0;
  logic              btn_down = 1'b0;
  logic              btn_next = 1'b0;
  logic              load_init = 1'b0;
  logic [NP*VW-1:0]  init_vals = INIT_V;
  logic [NP*VW-1:0]  max_vals = MAX_V;
  logic [NP*SW-1:0]  steps = STEP_V;
  logic [NP*VW-1:0]  values;
  logic [1:0]        sel;
  logic              step_pulse;

  int checks = 0;
  int failures = 0;

  param_adjust_ctrl #(
    .NUM_PARAMS    (NP),
    .VAL_W         (VW),
    .STEP_W        (SW),
    .HOLD_DELAY    (24'd4),
    .REPEAT_PERIOD (24'd2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_next   (btn_next),
    .init_vals  (init_vals),
    .max_vals   (max_vals),
    .steps      (steps),
    .load_init  (load_init),
    .values     (values),
    .sel        (sel),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] val_of(input int i);
    return values[i*VW +: VW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_next();
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (values !== '0) begin failures++; $display("FAIL reset_values got=%h exp=0", values); end
    repeat (2) tick();
    checks++;
    if (sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++;
    if (step_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%0b exp=0", step_pulse); end
    reset_n = 1'b1;
    tick();
    checks++;
    if (values !== INIT_V) begin failures++; $display("FAIL init_load got=%h exp=%h", values, INIT_V); end
    checks++;
    if (sel !== 2'd0) begin failures++; $display("FAIL init_sel got=%0d exp=0", sel); end
    checks++;
    if (step_pulse !== 1'b0) begin failures++; $display("FAIL init_pulse got=%0b exp=0", step_pulse); end
  endtask

  task automatic test_hold_repeat();
    int pc;
    logic exp_p;
    pc = 0;
    btn_up = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp_p = (k == 0) || (k == 4) || (k == 6) || (k == 8);
      checks++;
      if (step_pulse !== exp_p) begin
        failures++;
        $display("FAIL repeat_pulse_c%0d got=%0b exp=%0b", k, step_pulse, exp_p);
      end
      if (step_pulse === 1'b1) pc++;
    end
    btn_up = 1'b0;
    checks++;
    if (val_of(0) !== 11'd140) begin failures++; $display("FAIL repeat_value got=%0d exp=140", val_of(0)); end
    checks++;
    if (pc != 4) begin failures++; $display("FAIL repeat_count got=%0d exp=4", pc); end
    repeat (3) tick();
    checks++;
    if (val_of(0) !== 11'd140) begin failures++; $display("FAIL release_value got=%0d exp=140", val_of(0)); end
    checks++;
    if (step_pulse !== 1'b0) begin failures++; $display("FAIL release_pulse got=%0b exp=0", step_pulse); end
  endtask

  task automatic test_down_wrap();
    logic [VW-1:0] exp_v;
`ifdef ADJ_SATURATE_EN
    exp_v = 11'd0;
`else
    exp_v = 11'd10;
`endif
    pulse_next();
    pulse_next();
    checks++;
    if (sel !== 2'd2) begin failures++; $display("FAIL sel_after_two got=%0d exp=2", sel); end
    btn_down = 1'b1;
    tick();
    btn_down = 1'b0;
    checks++;
    if (val_of(2) !== exp_v) begin failures++; $display("FAIL down_bound got=%0d exp=%0d", val_of(2), exp_v); end
    checks++;
    if (step_pulse !== 1'b1) begin failures++; $display("FAIL down_pulse got=%0b exp=1", step_pulse); end
    tick();
    checks++;
    if (val_of(1) !== 11'd200) begin failures++; $display("FAIL other_param got=%0d exp=200", val_of(1)); end
  endtask

  task automatic test_up_wrap();
    logic [VW-1:0] exp_v;
`ifdef ADJ_SATURATE_EN
    exp_v = 11'd5;
`else
    exp_v = 11'd0;
`endif
    pulse_next();
    checks++;
    if (sel !== 2'd3) begin failures++; $display("FAIL sel_three got=%0d exp=3", sel); end
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    checks++;
    if (val_of(3) !== exp_v) begin failures++; $display("FAIL up_bound got=%0d exp=%0d", val_of(3), exp_v); end
    checks++;
    if (step_pulse !== 1'b1) begin failures++; $display("FAIL up_pulse got=%0b exp=1", step_pulse); end
    tick();
    pulse_next();
    checks++;
    if (sel !== 2'd0) begin failures++; $display("FAIL sel_wrap got=%0d exp=0", sel); end
  endtask

  task automatic test_both_buttons();
    int pc;
    pc = 0;
    btn_up = 1'b1;
    btn_down = 1'b1;
    repeat (3) begin
      tick();
      if (step_pulse === 1'b1) pc++;
    end
    btn_down = 1'b0;
    repeat (6) begin
      tick();
      if (step_pulse === 1'b1) pc++;
    end
    checks++;
    if (pc != 0) begin failures++; $display("FAIL both_pulses got=%0d exp=0", pc); end
    checks++;
    if (val_of(0) !== 11'd140) begin failures++; $display("FAIL both_value got=%0d exp=140", val_of(0)); end
    btn_up = 1'b0;
    tick();
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    checks++;
    if (val_of(0) !== 11'd150) begin failures++; $display("FAIL after_wait_step got=%0d exp=150", val_of(0)); end
    tick();
  endtask

  task automatic test_reset_mid_repeat();
    btn_up = 1'b1;
    repeat (6) tick();
    checks++;
    if (val_of(0) !== 11'd170) begin failures++; $display("FAIL pre_reset_value got=%0d exp=170", val_of(0)); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (values !== '0) begin failures++; $display("FAIL async_reset got=%h exp=0", values); end
    btn_up = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (values !== INIT_V) begin failures++; $display("FAIL reinit got=%h exp=%h", values, INIT_V); end
    checks++;
    if (sel !== 2'd0) begin failures++; $display("FAIL reinit_sel got=%0d exp=0", sel); end
  endtask

  task automatic test_load_init_hold();
    int pc;
    pc = 0;
    btn_up = 1'b1;
    tick();
    checks++;
    if (val_of(0) !== 11'd110) begin failures++; $display("FAIL load_pre_value got=%0d exp=110", val_of(0)); end
    repeat (3) tick();
    load_init = 1'b1;
    tick();
    load_init = 1'b0;
    checks++;
    if (values !== INIT_V) begin failures++; $display("FAIL load_values got=%h exp=%h", values, INIT_V); end
    checks++;
    if (step_pulse !== 1'b0) begin failures++; $display("FAIL load_pulse got=%0b exp=0", step_pulse); end
    repeat (6) begin
      tick();
      if (step_pulse === 1'b1) pc++;
    end
    checks++;
    if (pc != 0) begin failures++; $display("FAIL load_wait_pulses got=%0d exp=0", pc); end
    btn_up = 1'b0;
    tick();
    btn_down = 1'b1;
    tick();
    btn_down = 1'b0;
    checks++;
    if (val_of(0) !== 11'd90) begin failures++; $display("FAIL load_then_down got=%0d exp=90", val_of(0)); end
    tick();
  endtask

  initial begin
    test_reset();
    test_hold_repeat();
    test_down_wrap();
    test_up_wrap();
    test_both_buttons();
    test_reset_mid_repeat();
    test_load_init_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
